// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: stores {parity_error, rx_data} per rx_done, sticky overrun on drop.
// Optional macro UART_RX_FIFO_FWFT_EN selects first-word fall-through reads; default is registered read.
module uart_rx_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              parity_error,
    input  logic              rd_en,
    input  logic              clr_overrun,
    output logic [7:0]        rd_data,
    output logic              rd_perr,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [8:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overrun_q, overrun_d;
    logic              pop, push, drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign count = count_q;
    assign overrun = overrun_q;

    // A pop at full frees the slot the simultaneous write lands in.
    assign pop  = rd_en && !empty;
    assign push = rx_done && (!full || pop);
    assign drop = rx_done && !push;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        overrun_d = overrun_q;
        if (drop)
            overrun_d = 1'b1;
        else if (clr_overrun)
            overrun_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= {parity_error, rx_data};
    end

`ifdef UART_RX_FIFO_FWFT_EN
    logic [8:0] head;
    assign head     = mem[rd_ptr_q];
    assign rd_data  = empty ? 8'h00 : head[7:0];
    assign rd_perr  = empty ? 1'b0  : head[8];
    assign rd_valid = !empty;
`else
    logic [8:0] rd_entry_q, rd_entry_d;
    logic       rd_valid_q, rd_valid_d;

    always_comb begin
        rd_entry_d = pop ? mem[rd_ptr_q] : rd_entry_q;
        rd_valid_d = pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_entry_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_entry_q <= rd_entry_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_entry_q[7:0];
    assign rd_perr  = rd_entry_q[8];
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16); covers both read modes via UART_RX_FIFO_FWFT_EN.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       parity_error = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_overrun = 1'b0;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_fifo #(.ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .parity_error(parity_error), .rd_en(rd_en), .clr_overrun(clr_overrun),
        .rd_data(rd_data), .rd_perr(rd_perr), .rd_valid(rd_valid),
        .empty(empty), .full(full), .count(count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [7:0] d, input logic p);
        rx_data = d; parity_error = p; rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    // Pop one entry and check it against the expected head.
    task automatic rd_chk(input logic [7:0] d, input logic p);
`ifdef UART_RX_FIFO_FWFT_EN
        chk("rd_valid", 32'(rd_valid), 32'(1'b1));
        chk("rd_data", 32'(rd_data), 32'(d));
        chk("rd_perr", 32'(rd_perr), 32'(p));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
`else
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("rd_valid", 32'(rd_valid), 32'(1'b1));
        chk("rd_data", 32'(rd_data), 32'(d));
        chk("rd_perr", 32'(rd_perr), 32'(p));
`endif
    endtask

    initial begin
        // 1: reset state, then three bytes in order
        #2;
        chk("rst_empty", 32'(empty), 32'(1'b1));
        chk("rst_full", 32'(full), 32'(1'b0));
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'(1'b0));
        chk("rst_rd_valid", 32'(rd_valid), 32'(1'b0));
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        chk("rst_rd_perr", 32'(rd_perr), 32'(1'b0));
        tick();
        rst = 1'b0;
        tick();
        wr(8'h41, 1'b0);
        wr(8'h42, 1'b1);
        wr(8'h43, 1'b0);
        chk("t1_count3", 32'(count), 32'd3);
        rd_chk(8'h41, 1'b0);
        rd_chk(8'h42, 1'b1);
        rd_chk(8'h43, 1'b0);
        chk("t1_count0", 32'(count), 32'd0);
        chk("t1_empty", 32'(empty), 32'(1'b1));
        tick();
        chk("t1_valid_drop", 32'(rd_valid), 32'(1'b0));
`ifndef UART_RX_FIFO_FWFT_EN
        chk("t1_data_hold", 32'(rd_data), 32'h43);
`endif

        // 2: fill, overflow, drain
        for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
        chk("t2_full", 32'(full), 32'(1'b1));
        chk("t2_count16", 32'(count), 32'd16);
        chk("t2_ovr_pre", 32'(overrun), 32'(1'b0));
        wr(8'h10, 1'b1);
        chk("t2_overrun", 32'(overrun), 32'(1'b1));
        chk("t2_count_hold", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) rd_chk(8'(i), 1'b0);
        chk("t2_empty", 32'(empty), 32'(1'b1));
        chk("t2_count0", 32'(count), 32'd0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("t2_ovr_clr", 32'(overrun), 32'(1'b0));

        // 3: write and pop together at full
        for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
`ifdef UART_RX_FIFO_FWFT_EN
        chk("t3_head", 32'(rd_data), 32'h00);
`endif
        rx_data = 8'hAA; parity_error = 1'b0; rx_done = 1'b1; rd_en = 1'b1;
        tick();
        rx_done = 1'b0; rd_en = 1'b0;
`ifndef UART_RX_FIFO_FWFT_EN
        chk("t3_pop_data", 32'(rd_data), 32'h00);
        chk("t3_pop_valid", 32'(rd_valid), 32'(1'b1));
`endif
        chk("t3_count16", 32'(count), 32'd16);
        chk("t3_no_ovr", 32'(overrun), 32'(1'b0));
        for (int i = 1; i < 16; i++) rd_chk(8'(i), 1'b0);
        rd_chk(8'hAA, 1'b0);
        chk("t3_empty", 32'(empty), 32'(1'b1));

        // 4: rd_en on empty, then write + rd_en on empty
        tick();
        rd_en = 1'b1;
        tick();
        chk("t4_count0", 32'(count), 32'd0);
        chk("t4_valid0", 32'(rd_valid), 32'(1'b0));
        chk("t4_empty", 32'(empty), 32'(1'b1));
        rx_data = 8'h55; parity_error = 1'b1; rx_done = 1'b1;
        tick();
        rx_done = 1'b0; rd_en = 1'b0;
        chk("t4_count1", 32'(count), 32'd1);
`ifdef UART_RX_FIFO_FWFT_EN
        chk("t4_fwft_valid", 32'(rd_valid), 32'(1'b1));
`else
        chk("t4_std_valid", 32'(rd_valid), 32'(1'b0));
`endif
        rd_chk(8'h55, 1'b1);
        chk("t4_empty2", 32'(empty), 32'(1'b1));

        // 5: drop + clear in the same cycle keeps overrun set
        for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i), i[0]);
        wr(8'hEE, 1'b0);
        chk("t5_overrun", 32'(overrun), 32'(1'b1));
        rx_data = 8'hEF; rx_done = 1'b1; clr_overrun = 1'b1;
        tick();
        rx_done = 1'b0;
        chk("t5_set_wins", 32'(overrun), 32'(1'b1));
        chk("t5_count16", 32'(count), 32'd16);
        tick();
        clr_overrun = 1'b0;
        chk("t5_clr_alone", 32'(overrun), 32'(1'b0));
        wr(8'hF0, 1'b0);
        chk("t5_reset_ovr", 32'(overrun), 32'(1'b1));

        // 6: async reset with 5 entries held
        for (int i = 0; i < 11; i++) rd_chk(8'h20 + 8'(i), i[0]);
        chk("t6_count5", 32'(count), 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("t6_empty", 32'(empty), 32'(1'b1));
        chk("t6_count0", 32'(count), 32'd0);
        chk("t6_valid0", 32'(rd_valid), 32'(1'b0));
        chk("t6_overrun0", 32'(overrun), 32'(1'b0));
        tick();
        rst = 1'b0;
        tick();
        wr(8'h77, 1'b0);
        chk("t6_count1", 32'(count), 32'd1);
        rd_chk(8'h77, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
